// File: rtl/eco32f_dwb_wbuf.sv
// Posted write buffer between the LSU data Wishbone master and the system bus.
// Optional store coalescing into the newest queued entry: define DWB_WBUF_COALESCE_EN.
module eco32f_dwb_wbuf #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lsu_adr_i,
  input  logic        lsu_stb_i,
  input  logic        lsu_cyc_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_cti_i,
  input  logic [1:0]  lsu_bte_i,
  input  logic [31:0] lsu_dat_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [31:0] dwbm_adr_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_cyc_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic [2:0]  dwbm_cti_o,
  output logic [1:0]  dwbm_bte_o,
  output logic [31:0] dwbm_dat_o,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  input  logic        dwbm_rty_i,
  input  logic [31:0] dwbm_dat_i,
  output logic        wbuf_empty,
  output logic        wbuf_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} state_t;

  state_t                state_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  wr_ack_reg, wbuf_err_reg;
  logic [31:0]           m_adr_reg, m_dat_reg;
  logic [3:0]            m_sel_reg;
  logic                  m_stb_reg, m_cyc_reg;

  logic [29:0] adr_mem [DEPTH];
  logic [3:0]  sel_mem [DEPTH];
  logic [31:0] head_dat;

  logic                  bus_done, pop, full, wr_req, accept, push, merge, merge_hit, is_read;
  logic [DEPTH_LOG2-1:0] newest_idx, wr_idx;

  assign bus_done   = dwbm_ack_i | dwbm_err_i | dwbm_rty_i;
  assign pop        = (state_reg == M_WRITE) & bus_done;
  assign full       = (count_reg == CNT_FULL);
  assign is_read    = (state_reg == M_READ);
  assign newest_idx = wr_ptr_reg - PTR_ONE;
  // Registered ack blocks a second accept while the LSU still holds stb.
  assign wr_req     = lsu_cyc_i & lsu_stb_i & lsu_we_i & ~wr_ack_reg & ~is_read;

`ifdef DWB_WBUF_COALESCE_EN
  logic [29:0] last_adr_reg;
  // With a single entry the newest is the head, which is being (or about to be) issued.
  assign merge_hit = (count_reg > CNT_ONE) & (last_adr_reg == lsu_adr_i[31:2]);
`else
  assign merge_hit = 1'b0;
`endif

  // A slot freed by this cycle's pop is reusable by this cycle's push.
  assign accept = wr_req & (merge_hit | ~full | pop);
  assign push   = accept & ~merge_hit;
  assign merge  = accept & merge_hit;
  assign wr_idx = merge ? newest_idx : wr_ptr_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (push || (merge && lsu_sel_i[gi]))
        lane_mem[wr_idx] <= lsu_dat_i[8*gi +: 8];
    end
    assign head_dat[8*gi +: 8] = lane_mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr_reg] <= lsu_adr_i[31:2];
      sel_mem[wr_ptr_reg] <= lsu_sel_i;
    end else if (merge) begin
      sel_mem[newest_idx] <= sel_mem[newest_idx] | lsu_sel_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= M_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_ack_reg   <= 1'b0;
      wbuf_err_reg <= 1'b0;
      m_adr_reg    <= '0;
      m_dat_reg    <= '0;
      m_sel_reg    <= '0;
      m_stb_reg    <= 1'b0;
      m_cyc_reg    <= 1'b0;
`ifdef DWB_WBUF_COALESCE_EN
      last_adr_reg <= '0;
`endif
    end else begin
      wr_ack_reg   <= accept;
      wbuf_err_reg <= 1'b0;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
`ifdef DWB_WBUF_COALESCE_EN
      if (push) last_adr_reg <= lsu_adr_i[31:2];
`endif
      case (state_reg)
        M_IDLE: begin
          if (count_reg != '0) begin
            state_reg <= M_WRITE;
            m_adr_reg <= {adr_mem[rd_ptr_reg], 2'b00};
            m_sel_reg <= sel_mem[rd_ptr_reg];
            m_dat_reg <= head_dat;
            m_stb_reg <= 1'b1;
            m_cyc_reg <= 1'b1;
          end else if (lsu_cyc_i && lsu_stb_i && !lsu_we_i) begin
            state_reg <= M_READ;
          end
        end
        M_WRITE: begin
          if (bus_done) begin
            m_stb_reg    <= 1'b0;
            m_cyc_reg    <= 1'b0;
            wbuf_err_reg <= dwbm_err_i | dwbm_rty_i;
            state_reg    <= M_IDLE;
          end
        end
        M_READ: begin
          if (!lsu_cyc_i || (bus_done && (lsu_cti_i == 3'b111 || lsu_cti_i == 3'b000)))
            state_reg <= M_IDLE;
        end
        default: state_reg <= M_IDLE;
      endcase
    end
  end

  // Reads are a transparent passthrough; writes come from the registered head entry.
  always_comb begin
    dwbm_adr_o = is_read ? lsu_adr_i : m_adr_reg;
    dwbm_stb_o = is_read ? lsu_stb_i : m_stb_reg;
    dwbm_cyc_o = is_read ? lsu_cyc_i : m_cyc_reg;
    dwbm_sel_o = is_read ? lsu_sel_i : m_sel_reg;
    dwbm_we_o  = ~is_read & m_cyc_reg;
    dwbm_cti_o = is_read ? lsu_cti_i : (m_cyc_reg ? 3'b111 : 3'b000);
    dwbm_bte_o = is_read ? lsu_bte_i : 2'b00;
    dwbm_dat_o = m_dat_reg;
    lsu_dat_o  = is_read ? dwbm_dat_i : 32'h0;
    lsu_ack_o  = is_read ? dwbm_ack_i : wr_ack_reg;
    lsu_err_o  = is_read & (dwbm_err_i | dwbm_rty_i);
  end

  assign wbuf_empty = (count_reg == '0) & (state_reg != M_WRITE);
  assign wbuf_err   = wbuf_err_reg;

endmodule

// File: tb/tb_eco32f_dwb_wbuf.sv
// Randomized and directed bench for eco32f_dwb_wbuf: program-order memory model plus bus-side scoreboard.
module tb_eco32f_dwb_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_adr_i, lsu_dat_i, lsu_dat_o;
  logic        lsu_stb_i, lsu_cyc_i, lsu_we_i, lsu_ack_o, lsu_err_o;
  logic [3:0]  lsu_sel_i;
  logic [2:0]  lsu_cti_i;
  logic [1:0]  lsu_bte_i;
  logic [31:0] dwbm_adr_o, dwbm_dat_o, dwbm_dat_i;
  logic        dwbm_stb_o, dwbm_cyc_o, dwbm_we_o;
  logic [3:0]  dwbm_sel_o;
  logic [2:0]  dwbm_cti_o;
  logic [1:0]  dwbm_bte_o;
  logic        dwbm_ack_i, dwbm_err_i, dwbm_rty_i;
  logic        wbuf_empty, wbuf_err;

  always #5 clk = ~clk;

  eco32f_dwb_wbuf dut (
    .clk(clk), .rst(rst),
    .lsu_adr_i(lsu_adr_i), .lsu_stb_i(lsu_stb_i), .lsu_cyc_i(lsu_cyc_i),
    .lsu_sel_i(lsu_sel_i), .lsu_we_i(lsu_we_i), .lsu_cti_i(lsu_cti_i),
    .lsu_bte_i(lsu_bte_i), .lsu_dat_i(lsu_dat_i), .lsu_dat_o(lsu_dat_o),
    .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o),
    .dwbm_adr_o(dwbm_adr_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_cyc_o(dwbm_cyc_o),
    .dwbm_sel_o(dwbm_sel_o), .dwbm_we_o(dwbm_we_o), .dwbm_cti_o(dwbm_cti_o),
    .dwbm_bte_o(dwbm_bte_o), .dwbm_dat_o(dwbm_dat_o),
    .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i), .dwbm_rty_i(dwbm_rty_i),
    .dwbm_dat_i(dwbm_dat_i), .wbuf_empty(wbuf_empty), .wbuf_err(wbuf_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stores in program order; the bus must see them in that order.
  typedef struct packed {
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_wq[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] bus_mem [logic [29:0]];

  function automatic logic [31:0] init_val(input logic [29:0] a);
    return {a[27:0], 4'h9} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_val(a);
  endfunction

  // Bus slave: responds after lat waiting cycles, unless hold is set.
  int  lat = 1;
  bit  hold = 0;
  int  resp_once = 0;
  int  wait_cnt = 0;
  int  bus_writes = 0;
  int  cyc_no = 0;
  int  last_wr_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  initial begin
    wr_t e;
    logic [29:0] a;
    int r;
    dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_rty_i = 0; dwbm_dat_i = 0;
    forever begin
      @(negedge clk);
      dwbm_ack_i = 0; dwbm_err_i = 0; dwbm_rty_i = 0;
      if (!rst && dwbm_cyc_o && dwbm_stb_o && !hold) begin
        if (wait_cnt >= lat) begin
          wait_cnt = 0;
          a = dwbm_adr_o[31:2];
          if (dwbm_we_o) begin
            if (exp_wq.size() == 0) check("wr_unexpected", 1, 0);
            else begin
              e = exp_wq.pop_front();
              check("wr_adr", dwbm_adr_o, {e.adr, 2'b00});
              check("wr_sel", dwbm_sel_o, e.sel);
              check("wr_dat", dwbm_dat_o, e.dat);
              check("wr_cti", dwbm_cti_o, 3'b111);
            end
            r = resp_once;
            resp_once = 0;
            if (r == 1) dwbm_err_i = 1;
            else if (r == 2) dwbm_rty_i = 1;
            else begin
              dwbm_ack_i = 1;
              bus_mem[a] = merge_bytes(bus_rd(a), dwbm_dat_o, dwbm_sel_o);
            end
            bus_writes++;
            last_wr_cyc = cyc_no;
          end else begin
            check("rd_order", exp_wq.size(), 0);
            dwbm_dat_i = bus_rd(a);
            dwbm_ack_i = 1;
          end
        end else wait_cnt++;
      end else if (!(dwbm_cyc_o && dwbm_stb_o)) wait_cnt = 0;
    end
  end

  int err_hi = 0, err_rise = 0;
  bit err_prev = 0;
  initial forever begin
    @(negedge clk);
    #2;
    if (wbuf_err) begin
      err_hi++;
      if (!err_prev) err_rise++;
    end
    err_prev = wbuf_err;
  end

  task automatic lsu_idle();
    lsu_cyc_i = 0; lsu_stb_i = 0; lsu_we_i = 0; lsu_sel_i = 0;
    lsu_cti_i = 0; lsu_bte_i = 0; lsu_adr_i = 0; lsu_dat_i = 0;
  endtask

  task automatic model_store(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    wr_t e;
    logic [29:0] a;
    a = adr[31:2];
    ref_mem[a] = merge_bytes(ref_rd(a), dat, sel);
`ifdef DWB_WBUF_COALESCE_EN
    if (exp_wq.size() >= 2 && exp_wq[$].adr == a) begin
      e = exp_wq.pop_back();
      e.dat = merge_bytes(e.dat, dat, sel);
      e.sel = e.sel | sel;
      exp_wq.push_back(e);
      return;
    end
`endif
    e.adr = a; e.sel = sel; e.dat = dat;
    exp_wq.push_back(e);
  endtask

  // n: number of sampling points until the ack was seen (2 = ack in the cycle after stb).
  task automatic store(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                       output int n);
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 1; lsu_adr_i = adr; lsu_sel_i = sel;
    lsu_dat_i = dat; lsu_cti_i = 3'b111;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!lsu_ack_o && n < 200);
    if (!lsu_ack_o) check("store_timeout", 0, 1);
    else model_store(adr, sel, dat);
    @(posedge clk); #1;
    lsu_idle();
  endtask

  task automatic load(input logic [31:0] adr);
    int n;
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 0; lsu_adr_i = adr; lsu_sel_i = 4'hf;
    lsu_cti_i = 3'b000; lsu_bte_i = 2'b00;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!lsu_ack_o && n < 200);
    if (!lsu_ack_o) check("load_timeout", 0, 1);
    else begin
      check("ld_data", lsu_dat_o, ref_rd(adr[31:2]));
      check("ld_err", lsu_err_o, 0);
    end
    @(posedge clk); #1;
    lsu_idle();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); #2; n++; end
    while ((!wbuf_empty || exp_wq.size() != 0) && n < 300);
    check(tag, {wbuf_empty, exp_wq.size() == 0}, 2'b11);
  endtask

  initial begin
    int n, beats, saw, bw, e0, h0;
    logic [31:0] adr, last_st, d;
    rst = 1;
    lsu_idle();
    repeat (3) @(negedge clk);
    #2;
    check("rst_stb", dwbm_stb_o, 0);
    check("rst_cyc", dwbm_cyc_o, 0);
    check("rst_ack", lsu_ack_o, 0);
    check("rst_empty", wbuf_empty, 1);
    check("rst_err", wbuf_err, 0);
    check("rst_dat", lsu_dat_o, 0);
    @(posedge clk); #1;
    rst = 0;

    // Three posted stores, bus acks 2 cycles after stb.
    lat = 2;
    store(32'h100, 4'hf, 32'hAABBCCDD, n); check("st1_lat", n, 2);
    store(32'h104, 4'hf, 32'h01234567, n); check("st2_lat", n, 2);
    store(32'h108, 4'h3, 32'h89ABCDEF, n); check("st3_lat", n, 2);
    wait_drain("drain1");

    // Fill all four entries with the bus stalled, then a fifth store waits for a pop.
    hold = 1; lat = 0;
    for (int i = 0; i < 4; i++) begin
      store(32'h500 + 32'(4*i), 4'hf, 32'h5000_0000 + 32'(i), n);
      check("fill_lat", n, 2);
    end
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 1; lsu_adr_i = 32'h510; lsu_sel_i = 4'hf;
    lsu_dat_i = 32'h5555AAAA;
    saw = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); #2; if (lsu_ack_o) saw = 1; end
    check("full_noack", saw, 0);
    hold = 0;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!lsu_ack_o && n < 200);
    if (!lsu_ack_o) check("full_timeout", 0, 1);
    else begin
      check("full_ack_delay", cyc_no - last_wr_cyc, 1);
      model_store(32'h510, 4'hf, 32'h5555AAAA);
    end
    @(posedge clk); #1;
    lsu_idle();
    wait_drain("drain_full");

    // Store then immediate load of the same word: load must return the stored data.
    lat = 3;
    store(32'h200, 4'hf, 32'hDEADBEEF, n);
    load(32'h200);
    wait_drain("drain_raw");

    // 8-beat wrapping refill with empty buffer.
    lat = 1; beats = 0;
    @(posedge clk); #1;
    lsu_cyc_i = 1; lsu_stb_i = 1; lsu_we_i = 0; lsu_sel_i = 4'hf; lsu_bte_i = 2'b10;
    for (int b = 0; b < 8; b++) begin
      lsu_adr_i = 32'h600 + 32'(4*b);
      lsu_cti_i = (b == 7) ? 3'b111 : 3'b010;
      n = 0;
      do begin @(negedge clk); #2; n++; end while (!lsu_ack_o && n < 200);
      if (!lsu_ack_o) check("burst_timeout", 0, 1);
      else begin
        beats++;
        check("burst_dat", lsu_dat_o, ref_rd(lsu_adr_i[31:2]));
      end
      @(posedge clk); #1;
    end
    // Keep cyc asserted one cycle: once the 111 beat closed the read, nothing passes through.
    lsu_stb_i = 0;
    @(negedge clk); #2;
    check("burst_beats", beats, 8);
    check("burst_closed", dwbm_cyc_o, 0);
    @(posedge clk); #1;
    lsu_idle();

    // err then rty on posted writes: each drops its entry and pulses wbuf_err once.
    e0 = err_rise; h0 = err_hi;
    hold = 1; lat = 1;
    store(32'h800, 4'hf, 32'h80000001, n);
    store(32'h804, 4'hf, 32'h80000002, n);
    store(32'h808, 4'hf, 32'h80000003, n);
    resp_once = 1;
    hold = 0;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (exp_wq.size() != 2 && n < 200);
    resp_once = 2;
    wait_drain("drain_err");
    check("err_pulses", err_rise - e0, 2);
    check("err_width", err_hi - h0, 2);
    check("err_dropped", bus_mem.exists(30'(32'h800 >> 2)), 0);
    check("rty_dropped", bus_mem.exists(30'(32'h804 >> 2)), 0);
    check("after_err", bus_rd(30'(32'h808 >> 2)), 32'h80000003);

    // Reset in the middle of a write with two more entries queued.
    hold = 1;
    store(32'h900, 4'hf, 32'h9, n);
    store(32'h904, 4'hf, 32'h9, n);
    store(32'h908, 4'hf, 32'h9, n);
    @(negedge clk); #2;
    check("pre_rst_stb", dwbm_stb_o, 1);
    rst = 1;
    #1;
    check("rst_mid_stb", dwbm_stb_o, 0);
    check("rst_mid_cyc", dwbm_cyc_o, 0);
    check("rst_mid_empty", wbuf_empty, 1);
    @(posedge clk); #1;
    rst = 0;
    exp_wq.delete();
    hold = 0;
    bw = bus_writes;
    repeat (10) @(negedge clk);
    #2;
    check("rst_lost", bus_writes, bw);

`ifdef DWB_WBUF_COALESCE_EN
    hold = 1; lat = 0;
    store(32'hA00, 4'hf, 32'hA0A0A0A0, n);
    store(32'h300, 4'h8, 32'h11223344, n);
    store(32'h300, 4'h1, 32'h55667788, n); check("coal_lat", n, 2);
    bw = bus_writes;
    hold = 0;
    wait_drain("drain_coal");
    check("coal_writes", bus_writes - bw, 2);
`endif

    // Randomized mix of stores and loads under varying bus latency.
    last_st = 32'hFFFF_FFFF;
    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 0) lat = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6) begin
        do adr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; while (adr == last_st);
        last_st = adr;
        d = $urandom;
        store(adr, 4'($urandom_range(1, 15)), d, n);
      end else begin
        load({26'd0, 4'($urandom_range(0, 15)), 2'b00});
      end
    end
    wait_drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
